// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the memory burst controller.
package mem_burst_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_burst_fifo2.sv
// Two-entry FIFO with occupancy count; push and pop may coincide.
module mem_burst_fifo2 #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] slot [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = slot[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller in front of a single-port memory with 1-cycle read latency.
// Optional running checksum output enabled by MEM_BURST_CHECKSUM_EN.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
`ifdef MEM_BURST_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] ptr;
    logic [AW:0]   left;
    logic          inflight;
    logic          issue;
    logic          accept;
    logic          rd_pop;
    logic [1:0]    buf_count;
    logic [2:0]    occ;

    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign rd_valid  = (buf_count != 2'd0);
    assign rd_pop    = rd_valid && rd_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign mem_addr  = ptr;
    assign mem_d     = wr_data;
    // Words already committed to the buffer after this cycle's pop settles.
    assign occ       = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, rd_pop};

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nx = (cmd_wr == OP_WR) ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_cs = 1'b1;
                    mem_we = 1'b1;
                    if (left == (AW+1)'(1)) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if ((left != '0) && (occ < 3'd2)) begin
                    issue  = 1'b1;
                    mem_cs = 1'b1;
                end
                if ((left == '0) && !inflight && (buf_count == 2'd0)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            left     <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (accept) begin
                ptr  <= cmd_addr;
                left <= {1'b0, cmd_len} + (AW+1)'(1);
            end else if (mem_cs) begin
                ptr  <= ptr + AW'(1);
                left <= left - (AW+1)'(1);
            end
        end
    end

    mem_burst_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (mem_q),
        .pop  (rd_pop),
        .dout (rd_data),
        .count(buf_count)
    );

`ifdef MEM_BURST_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (accept) begin
            csum <= '0;
        end else if (wr_valid && wr_ready) begin
            csum <= csum + wr_data;
        end else if (rd_pop) begin
            csum <= csum + rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a behavioural 8x16 memory.
// Checksum checks are compiled in only when MEM_BURST_CHECKSUM_EN is defined.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [2:0]  cmd_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_cs;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_d;
    logic [15:0] mem_q;
`ifdef MEM_BURST_CHECKSUM_EN
    logic [15:0] csum;
    logic [15:0] done_csum;
`endif

    always #5 clk = ~clk;

    mem_burst_ctrl #(
        .DW(16),
        .AW(3)
    ) dut (
`ifdef MEM_BURST_CHECKSUM_EN
        .csum     (csum),
`endif
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .busy     (busy),
        .done     (done),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    // Memory model: registered q, rst_n tied to ~rst, contents survive reset.
    logic [15:0] mem [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                             16'h1004, 16'h1005, 16'h1006, 16'h1007};
    logic        mem_rst_n;
    assign mem_rst_n = ~rst;

    always @(posedge clk) begin
        if (!mem_rst_n) begin
            mem_q <= '0;
        end else if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_d;
            else        mem_q <= mem[mem_addr];
        end
    end

    logic [15:0] shadow [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                                16'h1004, 16'h1005, 16'h1006, 16'h1007};
    int          checks = 0;
    int          errors = 0;
    logic [15:0] beats [$];
    logic [15:0] wq [$];
    logic [2:0]  w_addr_exp;
    int          done_cnt, viol, first_beat, last_beat;
    logic        first_cs;
    logic        h_wr;
    logic [2:0]  h_addr, h_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [2:0] addr, input logic [2:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Runs from the first active cycle until done (or beat stop / cycle budget).
    task automatic run(input int mode, input bit hold, input int stop_beats, input int maxc);
        int   bbuf;
        logic binfl;
        logic pop;
        bbuf = 0;
        binfl = 1'b0;
        beats.delete();
        done_cnt = 0;
        viol = 0;
        first_beat = -1;
        last_beat = -1;
        first_cs = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            if (hold && c == 0) begin
                cmd_wr = h_wr;
                cmd_addr = h_addr;
                cmd_len = h_len;
            end
            rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (wq.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
            end
            #1;
            if (c == 0) first_cs = mem_cs;
            pop = rd_valid && rd_ready;
            if (pop) begin
                beats.push_back(rd_data);
                if (first_beat < 0) first_beat = c;
                last_beat = c;
            end
            if (mem_cs && !mem_we && (bbuf + int'(binfl) - int'(pop) >= 2)) viol++;
            if (busy && cmd_ready) viol++;
            if (mem_cs && mem_we) begin
                if (wq.size() == 0) begin
                    viol++;
                end else begin
                    check("wr_addr", {29'd0, mem_addr}, {29'd0, w_addr_exp});
                    check("wr_d", {16'd0, mem_d}, {16'd0, wq[0]});
                    shadow[w_addr_exp] = wq[0];
                    w_addr_exp = w_addr_exp + 3'd1;
                    void'(wq.pop_front());
                end
            end
            bbuf  = bbuf + int'(binfl) - int'(pop);
            binfl = mem_cs && !mem_we;
            if (done) begin
                done_cnt++;
`ifdef MEM_BURST_CHECKSUM_EN
                done_csum = csum;
`endif
                break;
            end
            if (stop_beats > 0 && beats.size() == stop_beats) break;
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_beats(input string tag, input logic [2:0] addr, input logic [2:0] len);
        logic [2:0] idx;
        check({tag, "_n"}, beats.size(), 32'(len) + 32'd1);
        for (int i = 0; i < beats.size() && i <= int'(len); i++) begin
            idx = addr + 3'(i);
            check(tag, {16'd0, beats[i]}, {16'd0, shadow[idx]});
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_mem_cs_we", {30'd0, mem_cs, mem_we}, 32'd0);
`ifdef MEM_BURST_CHECKSUM_EN
        check("rst_csum", {16'd0, csum}, 32'd0);
`endif

        // Write beat offered while idle must be refused.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data = 16'hDEAD;
        #1;
        check("idle_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("idle_mem_cs", {31'd0, mem_cs}, 32'd0);
        wr_valid = 1'b0;

        // Full-memory read, sustained.
        send_cmd(1'b0, 3'd0, 3'd7);
        run(0, 1'b0, 0, 100);
        check("r07_done", done_cnt, 1);
        check("r07_first_cs", {31'd0, first_cs}, 32'd1);
        check_beats("r07_data", 3'd0, 3'd7);
        check("r07_consec", last_beat - first_beat, 7);
        check("r07_viol", viol, 0);
`ifdef MEM_BURST_CHECKSUM_EN
        check("r07_csum", {16'd0, done_csum}, 32'h801C);
`endif
        check_idle_after("r07_after");

        // Throttled read: buffer limit must hold off issues.
        send_cmd(1'b0, 3'd2, 3'd5);
        run(1, 1'b0, 0, 200);
        check("r25_done", done_cnt, 1);
        check_beats("r25_data", 3'd2, 3'd5);
        check("r25_viol", viol, 0);

        // Command held across a burst; second command follows done.
        h_wr = 1'b0; h_addr = 3'd5; h_len = 3'd2;
        send_cmd(1'b0, 3'd3, 3'd1);
        run(0, 1'b1, 0, 100);
        check("hold1_done", done_cnt, 1);
        check_beats("hold1_data", 3'd3, 3'd1);
        check("hold1_viol", viol, 0);
        @(negedge clk);
        #1;
        check("hold_accept", {31'd0, cmd_ready}, 32'd1);
        run(0, 1'b0, 0, 100);
        check("hold2_done", done_cnt, 1);
        check_beats("hold2_data", 3'd5, 3'd2);

        // Wrapping write, then read back.
        send_cmd(1'b1, 3'd6, 3'd3);
        wq = '{16'hA0A0, 16'hA0A1, 16'hA0A2, 16'hA0A3};
        w_addr_exp = 3'd6;
        run(0, 1'b0, 0, 100);
        check("w63_done", done_cnt, 1);
        check("w63_left", wq.size(), 0);
        check("w63_viol", viol, 0);
`ifdef MEM_BURST_CHECKSUM_EN
        check("w63_csum", {16'd0, done_csum}, 32'h8286);
`endif
        check_idle_after("w63_after");
        send_cmd(1'b0, 3'd6, 3'd3);
        run(0, 1'b0, 0, 100);
        check_beats("r63_data", 3'd6, 3'd3);
        check("r63_mem1", {16'd0, (beats.size() == 4) ? beats[3] : 16'h0}, 32'hA0A3);

        // Reset in the middle of a read burst.
        send_cmd(1'b0, 3'd0, 3'd7);
        run(0, 1'b0, 3, 100);
        check("rst_mid_beats", beats.size(), 3);
        @(negedge clk);
        rst = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid_mem_cs", {31'd0, mem_cs}, 32'd0);
        send_cmd(1'b0, 3'd0, 3'd0);
        run(0, 1'b0, 0, 100);
        check("r00_done", done_cnt, 1);
        check_beats("r00_data", 3'd0, 3'd0);

        // Single-word write of all ones.
        send_cmd(1'b1, 3'd2, 3'd0);
        wq = '{16'hFFFF};
        w_addr_exp = 3'd2;
        run(0, 1'b0, 0, 100);
        check("w20_done", done_cnt, 1);
        check("w20_left", wq.size(), 0);
`ifdef MEM_BURST_CHECKSUM_EN
        check("w20_csum", {16'd0, done_csum}, 32'hFFFF);
`endif
        check_idle_after("w20_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
